// File: rtl/fab_ctrl_arbiter_pkg.sv
// fab_ctrl_arbiter_pkg: shared constants for the fabric-control arbiter.
// FSM encodings, unit id width and the maximum unit count.
package fab_ctrl_arbiter_pkg;

    localparam int UNIT_ID_W = 4;
    localparam int MAX_UNITS = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_OWN     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/fab_ctrl_arbiter_if.sv
// fab_ctrl_arbiter_if: request/grant bundle between fabric units and arbiter.
// master = unit side, slave = arbiter side.
interface fab_ctrl_arbiter_if #(
    parameter int N_UNITS = 4
);
    import fab_ctrl_arbiter_pkg::*;

    logic [N_UNITS-1:0]   REQUEST;
    logic                 BUSY_line_MASTER;
    logic [N_UNITS-1:0]   EN;
    logic                 GRANT_VALID;
    logic [UNIT_ID_W-1:0] GRANT_ID;
    logic                 TIMEOUT_ERR;

    modport master (
        output REQUEST, BUSY_line_MASTER,
        input  EN, GRANT_VALID, GRANT_ID, TIMEOUT_ERR
    );

    modport slave (
        input  REQUEST, BUSY_line_MASTER,
        output EN, GRANT_VALID, GRANT_ID, TIMEOUT_ERR
    );

endinterface

// File: rtl/fab_arb_rr_pick.sv
// fab_arb_rr_pick: combinational winner selection for the arbiter.
// FAB_ARB_FIXED_PRIO_EN turns it into a lowest-index priority encoder.
module fab_arb_rr_pick
    import fab_ctrl_arbiter_pkg::*;
#(
    parameter int N_UNITS = 4
) (
    input  logic [N_UNITS-1:0]   request,
`ifdef FAB_ARB_FIXED_PRIO_EN
`else
    input  logic [UNIT_ID_W-1:0] last,
`endif
    output logic [UNIT_ID_W-1:0] winner,
    output logic                 any
);

    assign any = |request;

`ifdef FAB_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = N_UNITS - 1; i >= 0; i--)
            if (request[i]) winner = UNIT_ID_W'(i);
    end
`else
    logic [MAX_UNITS-1:0] req_all;
    logic [UNIT_ID_W:0]   idx;

    assign req_all = MAX_UNITS'(request);

    // Walk from farthest to nearest so the first unit after last wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = N_UNITS; i >= 1; i--) begin
            idx = {1'b0, last} + (UNIT_ID_W + 1)'(i);
            if (idx >= (UNIT_ID_W + 1)'(N_UNITS))
                idx = idx - (UNIT_ID_W + 1)'(N_UNITS);
            if (req_all[idx[UNIT_ID_W-1:0]])
                winner = idx[UNIT_ID_W-1:0];
        end
    end
`endif

endmodule

// File: rtl/fab_ctrl_arbiter.sv
// fab_ctrl_arbiter: one-hot fabric bus grant with turnaround and watchdog.
// Define FAB_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module fab_ctrl_arbiter
    import fab_ctrl_arbiter_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input logic               CLK_B,
    input logic               RESET,
    fab_ctrl_arbiter_if.slave bus
);

    logic [1:0]           state;
    logic [N_UNITS-1:0]   en_q;
    logic                 valid_q;
    logic                 err_q;
    logic [UNIT_ID_W-1:0] id_q;
    logic [UNIT_ID_W-1:0] winner;
    logic [TO_W-1:0]      wd;
    logic                 any;
    logic [MAX_UNITS-1:0] req_all;
    logic                 busy;
    logic                 done;
    logic                 timeout;

    assign req_all = MAX_UNITS'(bus.REQUEST);
    assign busy    = bus.BUSY_line_MASTER;

    // Before the owner starts, withdrawing its request also ends the grant.
    assign done = (state == ST_OWN) ? !busy
                                    : (!busy && !req_all[id_q]);
    assign timeout = !done && (wd == TO_W'(TIMEOUT - 1));

`ifdef FAB_ARB_FIXED_PRIO_EN
    fab_arb_rr_pick #(.N_UNITS(N_UNITS)) u_pick (
        .request (bus.REQUEST),
        .winner  (winner),
        .any     (any)
    );
`else
    logic [UNIT_ID_W-1:0] last_q;

    fab_arb_rr_pick #(.N_UNITS(N_UNITS)) u_pick (
        .request (bus.REQUEST),
        .last    (last_q),
        .winner  (winner),
        .any     (any)
    );
`endif

    always_ff @(posedge CLK_B) begin
        if (RESET) begin
            state   <= ST_IDLE;
            en_q    <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            err_q   <= 1'b0;
            wd      <= '0;
`ifdef FAB_ARB_FIXED_PRIO_EN
`else
            last_q  <= UNIT_ID_W'(N_UNITS - 1);
`endif
        end else begin
            err_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any) begin
                        state   <= ST_GRANT;
                        en_q    <= N_UNITS'(1) << winner;
                        valid_q <= 1'b1;
                        id_q    <= winner;
                        wd      <= '0;
                    end
                end
                ST_GRANT, ST_OWN: begin
                    if (done || timeout) begin
                        state   <= ST_RELEASE;
                        en_q    <= '0;
                        valid_q <= 1'b0;
                        err_q   <= timeout;
                    end else begin
                        wd <= wd + 1'b1;
                        if (busy) state <= ST_OWN;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
`ifdef FAB_ARB_FIXED_PRIO_EN
`else
                    last_q <= id_q;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.EN          = en_q;
    assign bus.GRANT_VALID = valid_q;
    assign bus.GRANT_ID    = id_q;
    assign bus.TIMEOUT_ERR = err_q;

endmodule
